// File: rtl/debug_hex_mux_if.sv
// ---------------------------------------------------------------------------
// debug_hex_mux_if
// Bundles the debug-tap side of the HEX display selector.
//   ch_data   NUM_CH packed words of DIGITS nibbles, channel i at
//             [(i+1)*DIGITS*4-1 : i*DIGITS*4], MS digit at top
//   ch_valid  1 = channel i populated
//   sel       manual channel select (switches)
//   mode      00 live, 01 capture, 10 auto-scan, 11 hold
//   trig      capture trigger level (already synchronised)
//   hex_out   displayed nibbles, MS digit at top
//   cur_ch    channel currently shown / armed
//   cap_cnt   capture-event counter
//   captured  a capture has been taken since entering capture mode
// master: the taps/switches side; slave: the selector.
// ---------------------------------------------------------------------------
interface debug_hex_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DIGITS = 6
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*DIGITS*4-1:0] ch_data;
    logic [NUM_CH-1:0]          ch_valid;
    logic [SEL_W-1:0]           sel;
    logic [1:0]                 mode;
    logic                       trig;
    logic [DIGITS*4-1:0]        hex_out;
    logic [SEL_W-1:0]           cur_ch;
    logic [7:0]                 cap_cnt;
    logic                       captured;

    modport master (
        output ch_data, ch_valid, sel, mode, trig,
        input  hex_out, cur_ch, cap_cnt, captured
    );

    modport slave (
        input  ch_data, ch_valid, sel, mode, trig,
        output hex_out, cur_ch, cap_cnt, captured
    );
endinterface

// File: rtl/debug_hex_mux.sv
// ---------------------------------------------------------------------------
// debug_hex_mux
// Selects one of NUM_CH debug words and registers it onto DIGITS hex nibbles
// for the HexDriver bank. Modes: live select, edge-triggered snapshot
// capture, timed auto-scan over populated channels, and freeze.
// Ports:
//   Clk    system clock
//   Reset  asynchronous, active-high reset
//   dbg    debug_hex_mux_if.slave (channel data/valid, sel, mode, trig in;
//          hex_out, cur_ch, cap_cnt, captured out). All outputs registered.
// ---------------------------------------------------------------------------
module debug_hex_mux #(
    parameter int         NUM_CH     = 4,
    parameter int         DIGITS     = 6,
    parameter int         SCAN_TICKS = 25000000,
    parameter logic [3:0] FILL       = 4'h1
) (
    input  logic            Clk,
    input  logic            Reset,
    debug_hex_mux_if.slave  dbg
);
    localparam int SEL_W = $clog2(NUM_CH);
    localparam int HEX_W = DIGITS * 4;
    localparam int TMR_W = $clog2(SCAN_TICKS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_TICKS - 1);
    localparam logic [HEX_W-1:0] FILL_WORD = {DIGITS{FILL}};

    typedef enum logic [1:0] {
        MODE_LIVE = 2'b00,
        MODE_CAP  = 2'b01,
        MODE_SCAN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    // Channel word, or the fill pattern when the channel is out of range
    // or not populated.
    function automatic logic [HEX_W-1:0] ch_lookup(
        input logic [SEL_W-1:0]        c,
        input logic [NUM_CH*HEX_W-1:0] data,
        input logic [NUM_CH-1:0]       vld
    );
        logic [HEX_W-1:0] r;
        r = FILL_WORD;
        for (int j = 0; j < NUM_CH; j++) begin
            if (vld[j] && (32'(c) == j))
                r = data[j*HEX_W +: HEX_W];
        end
        return r;
    endfunction

    // Next populated channel above cur, wrapping to 0; cur itself when no
    // other channel is populated.
    function automatic logic [SEL_W-1:0] next_valid(
        input logic [SEL_W-1:0]  cur,
        input logic [NUM_CH-1:0] vld
    );
        logic [SEL_W-1:0] r;
        logic             found;
        r     = cur;
        found = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && vld[j] && (j > 32'(cur))) begin
                r     = SEL_W'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && vld[j] && (j < 32'(cur))) begin
                r     = SEL_W'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    mode_t            mode_q;
    mode_t            mode_in;
    logic             trig_q;
    logic             trig_edge;
    logic [HEX_W-1:0] hex_p1,  hex_nxt;
    logic [SEL_W-1:0] cur_q,   cur_nxt;
    logic [7:0]       cnt_q,   cnt_nxt;
    logic             capd_q,  capd_nxt;
    logic [TMR_W-1:0] tmr_q,   tmr_nxt;

    assign mode_in   = mode_t'(dbg.mode);
    assign trig_edge = dbg.trig & ~trig_q;

    always_comb begin
        hex_nxt  = hex_p1;
        cur_nxt  = cur_q;
        cnt_nxt  = cnt_q;
        capd_nxt = capd_q;
        tmr_nxt  = tmr_q;
        case (mode_in)
            MODE_LIVE: begin
                cur_nxt = dbg.sel;
                hex_nxt = ch_lookup(dbg.sel, dbg.ch_data, dbg.ch_valid);
            end
            MODE_CAP: begin
                cur_nxt = dbg.sel;
                // Entry clears the flag; an edge in the same cycle re-sets it.
                if (mode_q != MODE_CAP)
                    capd_nxt = 1'b0;
                if (trig_edge) begin
                    hex_nxt  = ch_lookup(dbg.sel, dbg.ch_data, dbg.ch_valid);
                    capd_nxt = 1'b1;
                    cnt_nxt  = cnt_q + 8'd1;
                end
            end
            MODE_SCAN: begin
                hex_nxt = ch_lookup(cur_q, dbg.ch_data, dbg.ch_valid);
                // Coming back from HOLD resumes; any other entry restarts.
                if (mode_q != MODE_SCAN && mode_q != MODE_HOLD) begin
                    cur_nxt = dbg.sel;
                    tmr_nxt = '0;
                end else if (tmr_q == TMR_LAST) begin
                    tmr_nxt = '0;
                    cur_nxt = next_valid(cur_q, dbg.ch_valid);
                end else begin
                    tmr_nxt = tmr_q + TMR_W'(1);
                end
            end
            default: ;  // MODE_HOLD: everything frozen
        endcase
    end

    // ---- register stage: display/control state -> outputs ----
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hex_p1 <= FILL_WORD;
            cur_q  <= '0;
            cnt_q  <= '0;
            capd_q <= 1'b0;
            tmr_q  <= '0;
            trig_q <= 1'b0;
            mode_q <= MODE_LIVE;
        end else begin
            hex_p1 <= hex_nxt;
            cur_q  <= cur_nxt;
            cnt_q  <= cnt_nxt;
            capd_q <= capd_nxt;
            tmr_q  <= tmr_nxt;
            trig_q <= dbg.trig;
            mode_q <= mode_in;
        end
    end

    assign dbg.hex_out  = hex_p1;
    assign dbg.cur_ch   = cur_q;
    assign dbg.cap_cnt  = cnt_q;
    assign dbg.captured = capd_q;

endmodule

// File: tb/tb_debug_hex_mux.sv
// ---------------------------------------------------------------------------
// tb_debug_hex_mux
// Table-driven check of live/capture/hold behaviour plus hand-written
// sequences for auto-scan, hold-resume, empty scan, async reset, counter
// wrap and held-trigger capture. NUM_CH=4, DIGITS=6, SCAN_TICKS=4.
// ---------------------------------------------------------------------------
module tb_debug_hex_mux;
    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    debug_hex_mux_if #(.NUM_CH(4), .DIGITS(6)) bus ();

    debug_hex_mux #(
        .NUM_CH(4), .DIGITS(6), .SCAN_TICKS(4), .FILL(4'h1)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .dbg   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        trig;
        logic [23:0] exp_hex;
        logic [1:0]  exp_ch;
        logic [7:0]  exp_cnt;
        logic        exp_capd;
    } vec_t;

    logic [23:0] chv [4];

    task automatic pack_data();
        bus.ch_data = {chv[3], chv[2], chv[1], chv[0]};
    endtask

    function automatic logic [23:0] data_of(input int c, input logic [3:0] vld);
        return vld[c] ? chv[c] : 24'h111111;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    vec_t vecs [16];
    int   seq [6];

    initial begin
        total = 0;
        bad   = 0;
        chv[0] = 24'h012345;
        chv[1] = 24'hABCDEF;
        chv[2] = 24'h123456;
        chv[3] = 24'h999999;
        pack_data();
        bus.ch_valid = 4'b1111;
        bus.sel      = 2'd0;
        bus.mode     = 2'b00;
        bus.trig     = 1'b0;
        Reset        = 1'b1;

        //            mode   sel  valid    trig  hex          ch  cnt  capd
        vecs[0]  = '{2'b00, 2'd1, 4'b1111, 1'b0, 24'hABCDEF, 2'd1, 8'd0, 1'b0};
        vecs[1]  = '{2'b00, 2'd3, 4'b0111, 1'b0, 24'h111111, 2'd3, 8'd0, 1'b0};
        vecs[2]  = '{2'b00, 2'd0, 4'b1111, 1'b0, 24'h012345, 2'd0, 8'd0, 1'b0};
        vecs[3]  = '{2'b00, 2'd2, 4'b1111, 1'b0, 24'h123456, 2'd2, 8'd0, 1'b0};
        vecs[4]  = '{2'b01, 2'd2, 4'b1111, 1'b0, 24'h123456, 2'd2, 8'd0, 1'b0};
        vecs[5]  = '{2'b01, 2'd1, 4'b1111, 1'b1, 24'hABCDEF, 2'd1, 8'd1, 1'b1};
        vecs[6]  = '{2'b01, 2'd2, 4'b1111, 1'b1, 24'hABCDEF, 2'd2, 8'd1, 1'b1};
        vecs[7]  = '{2'b01, 2'd2, 4'b1111, 1'b0, 24'hABCDEF, 2'd2, 8'd1, 1'b1};
        vecs[8]  = '{2'b01, 2'd2, 4'b1111, 1'b1, 24'h123456, 2'd2, 8'd2, 1'b1};
        vecs[9]  = '{2'b11, 2'd0, 4'b1111, 1'b0, 24'h123456, 2'd2, 8'd2, 1'b1};
        vecs[10] = '{2'b11, 2'd0, 4'b1111, 1'b1, 24'h123456, 2'd2, 8'd2, 1'b1};
        vecs[11] = '{2'b01, 2'd0, 4'b1111, 1'b1, 24'h123456, 2'd0, 8'd2, 1'b0};
        vecs[12] = '{2'b01, 2'd3, 4'b0111, 1'b0, 24'h123456, 2'd3, 8'd2, 1'b0};
        vecs[13] = '{2'b01, 2'd3, 4'b0111, 1'b1, 24'h111111, 2'd3, 8'd3, 1'b1};
        vecs[14] = '{2'b11, 2'd0, 4'b1111, 1'b0, 24'h111111, 2'd3, 8'd3, 1'b1};
        vecs[15] = '{2'b01, 2'd1, 4'b1111, 1'b1, 24'hABCDEF, 2'd1, 8'd4, 1'b1};

        // Reset state, asynchronously applied before any clock edge
        #1;
        check("rst hex",  32'(bus.hex_out),  32'h111111);
        check("rst ch",   32'(bus.cur_ch),   32'd0);
        check("rst cnt",  32'(bus.cap_cnt),  32'd0);
        check("rst capd", 32'(bus.captured), 32'd0);
        tick(2);
        Reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            bus.mode     = vecs[i].mode;
            bus.sel      = vecs[i].sel;
            bus.ch_valid = vecs[i].valid;
            bus.trig     = vecs[i].trig;
            tick(1);
            check($sformatf("v%0d hex", i),  32'(bus.hex_out),  32'(vecs[i].exp_hex));
            check($sformatf("v%0d ch", i),   32'(bus.cur_ch),   32'(vecs[i].exp_ch));
            check($sformatf("v%0d cnt", i),  32'(bus.cap_cnt),  32'(vecs[i].exp_cnt));
            check($sformatf("v%0d capd", i), 32'(bus.captured), 32'(vecs[i].exp_capd));
        end

        // Auto-scan over channels 0,1,3 (ch2 unpopulated), 4 cycles each
        seq = '{0, 1, 3, 0, 1, 3};
        bus.trig     = 1'b0;
        bus.ch_valid = 4'b1011;
        bus.sel      = 2'd0;
        bus.mode     = 2'b10;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("scan%0d ch", i), 32'(bus.cur_ch), 32'(seq[i/4]));
            if (i > 0)
                check($sformatf("scan%0d hex", i), 32'(bus.hex_out),
                      32'(data_of(seq[(i-1)/4], 4'b1011)));
            tick(1);
        end
        check("scan20 ch", 32'(bus.cur_ch), 32'd3);
        tick(2);

        // Hold mid-scan: timer sits at 2 with cur_ch 3; a reload would pick sel=1
        bus.mode = 2'b11;
        bus.sel  = 2'd1;
        tick(20);
        check("hold ch",  32'(bus.cur_ch),  32'd3);
        check("hold hex", 32'(bus.hex_out), 32'h999999);
        bus.mode = 2'b10;
        tick(1);
        check("resume1 ch", 32'(bus.cur_ch), 32'd3);
        tick(1);
        check("resume2 ch", 32'(bus.cur_ch), 32'd0);

        // Nothing populated: cur_ch never moves, display shows fill
        bus.ch_valid = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check($sformatf("empty%0d ch", i),  32'(bus.cur_ch),  32'd0);
            check($sformatf("empty%0d hex", i), 32'(bus.hex_out), 32'h111111);
        end

        // Async reset mid-scan with a non-zero counter
        bus.ch_valid = 4'b1111;
        tick(3);
        Reset = 1'b1;
        #1;
        check("arst hex",  32'(bus.hex_out),  32'h111111);
        check("arst ch",   32'(bus.cur_ch),   32'd0);
        check("arst cnt",  32'(bus.cap_cnt),  32'd0);
        check("arst capd", 32'(bus.captured), 32'd0);
        #1;
        Reset = 1'b0;
        tick(1);

        // 256 capture edges wrap the counter back to 0
        bus.mode = 2'b01;
        bus.sel  = 2'd2;
        bus.trig = 1'b0;
        tick(1);
        for (int k = 1; k <= 256; k++) begin
            bus.trig = 1'b1;
            tick(1);
            bus.trig = 1'b0;
            tick(1);
            if (k == 255)
                check("wrap255 cnt", 32'(bus.cap_cnt), 32'd255);
        end
        check("wrap cnt",  32'(bus.cap_cnt),  32'd0);
        check("wrap capd", 32'(bus.captured), 32'd1);
        check("wrap hex",  32'(bus.hex_out),  32'h123456);

        // Trigger held high for 10 cycles is a single capture; later data
        // changes without an edge do not reach the display
        bus.trig = 1'b1;
        tick(10);
        check("held cnt", 32'(bus.cap_cnt), 32'd1);
        check("held hex", 32'(bus.hex_out), 32'h123456);
        chv[2] = 24'h654321;
        pack_data();
        tick(3);
        check("noedge hex", 32'(bus.hex_out), 32'h123456);
        check("noedge cnt", 32'(bus.cap_cnt), 32'd1);
        bus.trig = 1'b0;
        bus.mode = 2'b00;
        tick(1);
        check("live new hex", 32'(bus.hex_out), 32'h654321);
        check("live cnt",     32'(bus.cap_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
